spi_cmd_controller: RTL

- Command sequencer behind the SPI receive byte buffer.
- Consumes each completed receive byte (8-bit byte plus byte-complete flag), decodes a command/address/data protocol, and drives a single-port register-file interface.
- Loads the next transmit byte for read-back.
- Owns the buffer's IsInitialized enable, holding the receive path off until a post-reset settle count expires.

---
 rtl/spi_cmd_controller.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_controller.sv
// Command sequencer behind the SPI receive byte buffer: decodes cmd/addr/data frames into register-file accesses.
// Optional macro SPI_CMD_AUTO_INC_EN makes reg_addr step by one after every register access.
module spi_cmd_controller #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INIT_CYCLES = 16,
  parameter int MAX_BURST   = 16
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  CS,
  input  logic [7:0]            Buffer,
  input  logic                  Changed,
  output logic                  IsInitialized,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [7:0]            reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [7:0]            reg_rdata,
  output logic [7:0]            tx_byte,
  output logic                  busy,
  output logic                  error
);

  localparam int CNT_W = $clog2(INIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES);
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR_WR, ADDR_RD, DATA_WR, DATA_RD, ERR
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      init_cnt_q, init_cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  changed_q, changed_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic [7:0]            tx_q, tx_d;
  logic [7:0]            burst_q, burst_d;
  logic                  error_q, error_d;
  logic                  strb;

  assign strb = Changed & ~changed_q & init_done_q & ~CS;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q | (init_cnt_q == INIT_LAST);
    changed_d   = Changed;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    tx_d        = tx_q;
    burst_d     = burst_q;
    error_d     = error_q;

    if (init_cnt_q != INIT_LAST) init_cnt_d = init_cnt_q + 1'b1;

    // Read data is only valid in the strobe cycle, so it is captured right then.
    if (re_q) tx_d = reg_rdata;

`ifdef SPI_CMD_AUTO_INC_EN
    if (we_q || re_q) addr_d = addr_q + 1'b1;
`endif

    if (state_q == IDLE) burst_d = '0;

    if (CS) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = CMD;
        CMD: begin
          if (strb) begin
            unique case (Buffer)
              8'h01: state_d = ADDR_WR;
              8'h02: state_d = ADDR_RD;
              8'h03: begin
                error_d = 1'b0;
                state_d = ERR;
              end
              default: begin
                error_d = 1'b1;
                state_d = ERR;
              end
            endcase
          end
        end
        ADDR_WR: begin
          if (strb) begin
            addr_d  = Buffer[ADDR_WIDTH-1:0];
            state_d = DATA_WR;
          end
        end
        ADDR_RD: begin
          if (strb) begin
            addr_d  = Buffer[ADDR_WIDTH-1:0];
            re_d    = 1'b1;
            state_d = DATA_RD;
          end
        end
        DATA_WR: begin
          if (strb) begin
            if (burst_q == BURST_MAX) begin
              error_d = 1'b1;
              state_d = ERR;
            end else begin
              we_d    = 1'b1;
              wdata_d = Buffer;
              burst_d = burst_q + 1'b1;
            end
          end
        end
        DATA_RD: begin
          if (strb) begin
            if (burst_q == BURST_MAX) begin
              error_d = 1'b1;
              state_d = ERR;
            end else begin
              re_d    = 1'b1;
              burst_d = burst_q + 1'b1;
            end
          end
        end
        ERR:     state_d = ERR;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      changed_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      tx_q        <= '0;
      burst_q     <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      changed_q   <= changed_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      re_q        <= re_d;
      tx_q        <= tx_d;
      burst_q     <= burst_d;
      error_q     <= error_d;
    end
  end

  assign IsInitialized = init_done_q;
  assign reg_addr      = addr_q;
  assign reg_wdata     = wdata_q;
  assign reg_we        = we_q;
  assign reg_re        = re_q;
  assign tx_byte       = tx_q;
  assign busy          = (state_q != IDLE);
  assign error         = error_q;

endmodule
